// File: rtl/var_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// var_write_arbiter_if
// Bundles the request/grant signals and the shared-variable outputs of
// var_write_arbiter. The requester side uses the master modport and the
// arbiter uses the slave modport.
//
// Signals:
//   req          [NREQ]        per-requester request
//   lock         [NREQ]        per-requester burst-lock request
//   op           [NREQ]        per-requester op: 0 = load data, 1 = invert q
//   data         [NREQ*WIDTH]  per-requester load data, slice i = [i*WIDTH +: WIDTH]
//   gnt          [NREQ]        one-hot grant (combinational)
//   q            [WIDTH]       shared variable (registered)
//   owned        1             a locked owner holds the resource
//   conflict_cnt [CNT_W]       saturating count of cycles with >1 request
// ----------------------------------------------------------------------------
interface var_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       op;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  owned;
    logic [CNT_W-1:0]      conflict_cnt;

    modport master (
        output req, lock, op, data,
        input  gnt, q, owned, conflict_cnt
    );

    modport slave (
        input  req, lock, op, data,
        output gnt, q, owned, conflict_cnt
    );
endinterface

// File: rtl/var_write_arbiter.sv
// ----------------------------------------------------------------------------
// var_write_arbiter
// Sole writer of a shared WIDTH-bit variable q. NREQ requesters ask to load
// their data or to invert q; a round-robin arbiter grants one per cycle, and
// a granted requester holding lock keeps the grant for up to LOCK_MAX cycles.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active-high (also forces gnt to 0 at once)
//   bus   slave modport of var_write_arbiter_if (req/lock/op/data in,
//         gnt/q/owned/conflict_cnt out)
//
// Build option:
//   VAR_ARB_CONFLICT_CNT_EN  when defined, conflict_cnt counts edges with
//                            more than one request (saturating); otherwise
//                            conflict_cnt is tied to 0.
// ----------------------------------------------------------------------------
module var_write_arbiter #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(12),
    parameter int               LOCK_MAX  = 8,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    var_write_arbiter_if.slave bus
);
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t            r_state, w_state_next;
    logic [IDX_W-1:0]  r_owner, w_owner_next;
    logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_next;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
    logic [WIDTH-1:0]  r_q;

    logic              w_rr_found;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_use_rr;
    logic              w_gnt_any;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [WIDTH-1:0]  w_data [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign w_data[gi] = bus.data[gi*WIDTH +: WIDTH];
            // Grant is masked by rst so it drops immediately on async reset.
            assign bus.gnt[gi] = w_gnt_any && !rst && (w_gnt_idx == IDX_W'(gi));
        end
    endgenerate

    // Round-robin search: first active request at rr_ptr, rr_ptr+1, ... mod NREQ.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(r_rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IDX_W'(cand);
            if (!w_rr_found && bus.req[cand_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = cand_idx;
            end
        end
    end

    // Next-state and grant selection.
    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_hold_cnt_next = r_hold_cnt;
        w_use_rr        = 1'b0;
        w_gnt_any       = 1'b0;
        w_gnt_idx       = '0;

        case (r_state)
            S_IDLE: begin
                w_use_rr = 1'b1;
            end
            S_OWNED: begin
                w_state_next    = S_IDLE;
                w_hold_cnt_next = '0;
                if (r_hold_cnt == HOLD_W'(LOCK_MAX)) begin
                    // Forced release: the owner is not granted; others arbitrate
                    // this same cycle and the owner already ranks last.
                    w_use_rr = 1'b1;
                end else if (bus.req[r_owner]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = r_owner;
                    if (bus.lock[r_owner]) begin
                        w_state_next    = S_OWNED;
                        w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_hold_cnt_next = '0;
            end
        endcase

        if (w_use_rr && w_rr_found) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_rr_idx;
            if (bus.lock[w_rr_idx]) begin
                w_state_next    = S_OWNED;
                w_owner_next    = w_rr_idx;
                w_hold_cnt_next = HOLD_W'(1);
            end
        end
    end

    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_gnt_any) begin
            w_rr_ptr_next = (w_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_q        <= RESET_VAL;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_hold_cnt <= w_hold_cnt_next;
            if (w_gnt_any) begin
                r_q <= bus.op[w_gnt_idx] ? ~r_q : w_data[w_gnt_idx];
            end
        end
    end

    assign bus.q     = r_q;
    assign bus.owned = (r_state == S_OWNED);

`ifdef VAR_ARB_CONFLICT_CNT_EN
    localparam int PC_W = $clog2(NREQ + 1);

    logic [PC_W-1:0]  w_req_pop;
    logic [CNT_W-1:0] r_conflict_cnt;

    always_comb begin
        w_req_pop = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_req_pop = w_req_pop + PC_W'(bus.req[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if ((w_req_pop > PC_W'(1)) && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign bus.conflict_cnt = r_conflict_cnt;
`else
    assign bus.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_var_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_var_write_arbiter
// Drives var_write_arbiter through reset, load/invert writes, round-robin
// rotation, burst lock with forced release and async reset mid-lock.
// Expected q values are queued when a cycle is driven and compared after the
// clock edge that performs the write.
// ----------------------------------------------------------------------------
module tb_var_write_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;

    var_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    var_write_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .RESET_VAL(32'd12),
        .LOCK_MAX (8),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] model_q;
    logic [WIDTH-1:0] q_sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.op    = '0;
        bus.data  = '0;
        tick();
        tick();
        rst       = 1'b0;
        model_q   = 32'd12;
    endtask

    // One arbitration cycle: drive, check grant/owned, queue expected q,
    // clock it in and compare q.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] o, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                       input logic [WIDTH-1:0] d3, input logic [3:0] eg,
                       input logic eo);
        logic [NREQ*WIDTH-1:0] dv;
        logic [WIDTH-1:0]      nq;
        logic [WIDTH-1:0]      got_q;
        logic [WIDTH-1:0]      exp_q;
        dv       = {d3, d2, d1, d0};
        bus.req  = r;
        bus.lock = l;
        bus.op   = o;
        bus.data = dv;
        #1;
        check_eq({tag, "_gnt"}, 64'(bus.gnt), 64'(eg));
        check_eq({tag, "_owned"}, 64'(bus.owned), 64'(eo));
        nq = model_q;
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) nq = o[i] ? ~model_q : dv[i*WIDTH +: WIDTH];
        end
        model_q = nq;
        q_sb.push_back(nq);
        tick();
        got_q = bus.q;
        exp_q = q_sb.pop_front();
        check_eq({tag, "_q"}, 64'(got_q), 64'(exp_q));
    endtask

    initial begin
        logic [CNT_W-1:0] exp_cnt;
        logic [3:0]       g4 [5];
        logic [3:0]       eg;
        logic             eo;

        rst      = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.op   = '0;
        bus.data = '0;
        #2;
        check_eq("reset_q", 64'(bus.q), 64'd12);
        check_eq("reset_gnt", 64'(bus.gnt), 64'd0);
        check_eq("reset_owned", 64'(bus.owned), 64'd0);
        check_eq("reset_cnt", 64'(bus.conflict_cnt), 64'd0);
        tick();
        rst     = 1'b0;
        model_q = 32'd12;

        // Single load
        cyc("load0", 4'b0001, 4'b0000, 4'b0000, 32'hA5, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0);

        // Async reset mid-cycle, no clock edge in between
        bus.req = 4'b0000;
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_q", 64'(bus.q), 64'd12);
        check_eq("async_rst_gnt", 64'(bus.gnt), 64'd0);
        check_eq("async_rst_owned", 64'(bus.owned), 64'd0);
        model_q = 32'd12;
        tick();
        rst = 1'b0;

        // Invert twice: 12 -> ~12 -> 12
        cyc("inv1", 4'b0010, 4'b0000, 4'b0010, 32'h0, 32'hDEAD, 32'h0, 32'h0, 4'b0010, 1'b0);
        check_eq("inv1_value", 64'(bus.q), 64'hFFFF_FFF3);
        cyc("inv2", 4'b0010, 4'b0000, 4'b0010, 32'h0, 32'hDEAD, 32'h0, 32'h0, 4'b0010, 1'b0);
        check_eq("inv2_value", 64'(bus.q), 64'd12);

        // Round-robin rotation with all requesting, including the 3 -> 0 wrap
        do_reset();
        g4[0] = 4'b0001; g4[1] = 4'b0010; g4[2] = 4'b0100; g4[3] = 4'b1000; g4[4] = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            cyc($sformatf("rr%0d", c), 4'b1111, 4'b0000, 4'b0000,
                32'h11, 32'h22, 32'h33, 32'h44, g4[c], 1'b0);
        end
`ifdef VAR_ARB_CONFLICT_CNT_EN
        exp_cnt = CNT_W'(5);
`else
        exp_cnt = '0;
`endif
        check_eq("conflict_cnt", 64'(bus.conflict_cnt), 64'(exp_cnt));

        // Burst lock by requester 1 against requester 2, forced release after 8.
        // owned follows the registered state: high from the cycle after the
        // locking grant through the release cycle, low the cycle after.
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            eg = (c == 9) ? 4'b0100 : 4'b0010;
            eo = ((c >= 2) && (c <= 9)) || (c >= 11);
            cyc($sformatf("lock_c%0d", c), 4'b0110, 4'b0010, 4'b0000,
                32'h0, 32'h100 + 32'(c), 32'h200 + 32'(c), 32'h0, eg, eo);
        end

        // Async reset in the middle of a lock
        do_reset();
        cyc("mid_lock1", 4'b0001, 4'b0001, 4'b0000, 32'h61, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0);
        cyc("mid_lock2", 4'b0001, 4'b0001, 4'b0000, 32'h62, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b1);
        bus.data = {96'h0, 32'h63};
        #1;
        check_eq("mid_lock3_gnt", 64'(bus.gnt), 64'b0001);
        check_eq("mid_lock3_owned", 64'(bus.owned), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_lock_rst_gnt", 64'(bus.gnt), 64'd0);
        check_eq("mid_lock_rst_owned", 64'(bus.owned), 64'd0);
        check_eq("mid_lock_rst_q", 64'(bus.q), 64'd12);
        model_q = 32'd12;
        tick();
        rst = 1'b0;
        cyc("post_rst", 4'b0011, 4'b0000, 4'b0000, 32'h71, 32'h72, 32'h0, 32'h0, 4'b0001, 1'b0);

        // Lock without request is ignored
        cyc("lock_noreq1", 4'b0100, 4'b1001, 4'b0000, 32'h0, 32'h0, 32'h81, 32'h0, 4'b0100, 1'b0);
        cyc("lock_noreq2", 4'b0000, 4'b1001, 4'b0000, 32'h0, 32'h0, 32'h82, 32'h0, 4'b0000, 1'b0);

        // Lock dropped by the owner: final grant still writes, then unlocked
        cyc("drop1", 4'b1000, 4'b1000, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h87, 4'b1000, 1'b0);
        cyc("drop2", 4'b1000, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h88, 4'b1000, 1'b1);
        cyc("drop3", 4'b1000, 4'b0000, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h89, 4'b1000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
